// File: rtl/dso100fb_trace_overlay.sv
// Oscilloscope trace + graticule overlay source for the video mixer.
// Double-buffered sample RAM; the output register always holds the next pixel to be consumed.
module dso100fb_trace_overlay #(
  parameter int ADDR_W     = 10,
  parameter int SAMPLE_W   = 12,
  parameter int GRID_PITCH = 50
) (
  input  logic                VIDCLK,
  input  logic                RST,
  input  logic                OVERLAY_SYNC,
  input  logic                OVERLAY_EN,
  output logic                OVERLAY_VALID,
  output logic [31:0]         OVERLAY_DATA,
  input  logic [11:0]         WIDTH,
  input  logic [11:0]         HEIGHT,
  input  logic                GRID_EN,
  input  logic [31:0]         TRACE_COLOR,
  input  logic [31:0]         GRID_COLOR,
  input  logic                SAMPLE_WE,
  input  logic [ADDR_W-1:0]   SAMPLE_ADDR,
  input  logic [SAMPLE_W-1:0] SAMPLE_DATA,
  input  logic                SWAP,
  output logic                SWAP_PENDING,
  output logic                SWAP_DONE
);

  localparam int GW    = (GRID_PITCH > 1) ? $clog2(GRID_PITCH) : 1;
  localparam int DEPTH = 2 ** (ADDR_W + 1);

  logic [SAMPLE_W-1:0] mem_q [0:DEPTH-1];

  logic              bank_q, bank_d;
  logic              pending_q, pending_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [11:0]       r_q, r_d;
  logic [GW-1:0]     gx_q, gx_d, gr_q, gr_d;
  logic              valid_q, valid_d;
  logic [31:0]       data_q, data_d;

  logic [SAMPLE_W-1:0] s_rd, p_rd, lo, hi;
  logic [11:0]         v;
  logic                in_rows, on_trace, on_grid;

  // Counters and bank select for the pixel that will be presented next cycle.
  always_comb begin
    x_d       = x_q;
    r_d       = r_q;
    gx_d      = gx_q;
    gr_d      = gr_q;
    bank_d    = bank_q;
    pending_d = pending_q | SWAP;
    done_d    = 1'b0;
    if (OVERLAY_SYNC) begin
      x_d  = '0;
      r_d  = '0;
      gx_d = '0;
      gr_d = '0;
      if (pending_q || SWAP) begin
        bank_d    = ~bank_q;
        pending_d = 1'b0;
        done_d    = 1'b1;
      end
    end else if (OVERLAY_EN) begin
      // ">=" rather than "==" so a mid-frame WIDTH shrink cannot strand x past the end.
      if (32'(x_q) + 32'd1 >= 32'(WIDTH)) begin
        x_d  = '0;
        gx_d = '0;
        if (r_q < HEIGHT) begin
          r_d  = r_q + 12'd1;
          gr_d = (gr_q == GW'(GRID_PITCH - 1)) ? '0 : gr_q + GW'(1);
        end
      end else begin
        x_d  = x_q + ADDR_W'(1);
        gx_d = (gx_q == GW'(GRID_PITCH - 1)) ? '0 : gx_q + GW'(1);
      end
    end
  end

  // Lookahead read of the display bank at the next column and its left neighbour.
  always_comb begin
    s_rd     = mem_q[{bank_d, x_d}];
    p_rd     = (x_d == '0) ? s_rd : mem_q[{bank_d, x_d - ADDR_W'(1)}];
    lo       = (s_rd < p_rd) ? s_rd : p_rd;
    hi       = (s_rd < p_rd) ? p_rd : s_rd;
    in_rows  = (r_d < HEIGHT);
    v        = HEIGHT - 12'd1 - r_d;
    on_trace = in_rows && (32'(lo) <= 32'(v)) && (32'(v) <= 32'(hi));
    on_grid  = in_rows && GRID_EN && ((gx_d == '0) || (gr_d == '0));
    valid_d  = 1'b0;
    data_d   = '0;
    if (on_trace) begin
      valid_d = 1'b1;
      data_d  = TRACE_COLOR;
    end else if (on_grid) begin
      valid_d = 1'b1;
      data_d  = GRID_COLOR;
    end
  end

  always_ff @(posedge VIDCLK) begin
    if (RST) begin
      bank_q    <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      x_q       <= '0;
      r_q       <= '0;
      gx_q      <= '0;
      gr_q      <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      bank_q    <= bank_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      x_q       <= x_d;
      r_q       <= r_d;
      gx_q      <= gx_d;
      gr_q      <= gr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  // Writes always land in the back bank; the display bank is read-only.
  always_ff @(posedge VIDCLK) begin
    if (SAMPLE_WE) mem_q[{~bank_q, SAMPLE_ADDR}] <= SAMPLE_DATA;
  end

  assign OVERLAY_VALID = valid_q;
  assign OVERLAY_DATA  = data_q;
  assign SWAP_PENDING  = pending_q;
  assign SWAP_DONE     = done_q;

endmodule

// File: tb/tb_dso100fb_trace_overlay.sv
// Bench for dso100fb_trace_overlay: raster-level reference model of the trace/grid rules.
module tb_dso100fb_trace_overlay;

  localparam int ADDR_W = 10;
  localparam int SAMPLE_W = 12;
  localparam int GP = 50;

  logic                VIDCLK = 1'b0;
  logic                RST = 1'b1;
  logic                OVERLAY_SYNC = 1'b0;
  logic                OVERLAY_EN = 1'b0;
  logic                OVERLAY_VALID;
  logic [31:0]         OVERLAY_DATA;
  logic [11:0]         WIDTH = 12'd8;
  logic [11:0]         HEIGHT = 12'd8;
  logic                GRID_EN = 1'b0;
  logic [31:0]         TRACE_COLOR = 32'h00FF0000;
  logic [31:0]         GRID_COLOR = 32'h0000FF00;
  logic                SAMPLE_WE = 1'b0;
  logic [ADDR_W-1:0]   SAMPLE_ADDR = '0;
  logic [SAMPLE_W-1:0] SAMPLE_DATA = '0;
  logic                SWAP = 1'b0;
  logic                SWAP_PENDING;
  logic                SWAP_DONE;

  dso100fb_trace_overlay #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .GRID_PITCH(GP)) dut (
    .VIDCLK(VIDCLK), .RST(RST), .OVERLAY_SYNC(OVERLAY_SYNC), .OVERLAY_EN(OVERLAY_EN),
    .OVERLAY_VALID(OVERLAY_VALID), .OVERLAY_DATA(OVERLAY_DATA), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .GRID_EN(GRID_EN), .TRACE_COLOR(TRACE_COLOR), .GRID_COLOR(GRID_COLOR),
    .SAMPLE_WE(SAMPLE_WE), .SAMPLE_ADDR(SAMPLE_ADDR), .SAMPLE_DATA(SAMPLE_DATA),
    .SWAP(SWAP), .SWAP_PENDING(SWAP_PENDING), .SWAP_DONE(SWAP_DONE)
  );

  // Clock / reset
  always #5 VIDCLK = ~VIDCLK;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  int ref_mem [2][1024];
  int ref_bank = 0;
  bit ref_pending = 0;
  bit exp_done = 0;

  function automatic logic [32:0] ref_pixel(int x, int r);
    int h, v, s, p, lo, hi;
    h = int'(HEIGHT);
    if (r >= h) return 33'd0;
    v  = h - 1 - r;
    s  = ref_mem[ref_bank][x];
    p  = (x == 0) ? s : ref_mem[ref_bank][x-1];
    lo = (s < p) ? s : p;
    hi = (s < p) ? p : s;
    if (v >= lo && v <= hi) return {1'b1, TRACE_COLOR};
    if (GRID_EN && ((x % GP) == 0 || (r % GP) == 0)) return {1'b1, GRID_COLOR};
    return 33'd0;
  endfunction

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge VIDCLK);
  endtask

  task automatic consume(output logic ov, output logic [31:0] od);
    @(negedge VIDCLK);
    ov = OVERLAY_VALID;
    od = OVERLAY_DATA;
    OVERLAY_EN = 1'b1;
    @(posedge VIDCLK);
    #1 OVERLAY_EN = 1'b0;
  endtask

  task automatic write_sample(input int addr, input int val);
    @(negedge VIDCLK);
    SAMPLE_WE = 1'b1;
    SAMPLE_ADDR = ADDR_W'(addr);
    SAMPLE_DATA = SAMPLE_W'(val);
    @(posedge VIDCLK);
    #1 SAMPLE_WE = 1'b0;
    ref_mem[1-ref_bank][addr] = val;
  endtask

  task automatic pulse_swap();
    @(negedge VIDCLK);
    SWAP = 1'b1;
    @(posedge VIDCLK);
    #1 SWAP = 1'b0;
    ref_pending = 1;
  endtask

  task automatic do_sync(input bit sw);
    @(negedge VIDCLK);
    OVERLAY_SYNC = 1'b1;
    SWAP = sw;
    @(posedge VIDCLK);
    #1 OVERLAY_SYNC = 1'b0;
    SWAP = 1'b0;
    if (ref_pending || sw) begin
      ref_bank = 1 - ref_bank;
      ref_pending = 0;
      exp_done = 1;
    end else begin
      exp_done = 0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge VIDCLK);
    @(negedge VIDCLK);
    total_cnt++;
    if ({OVERLAY_VALID, OVERLAY_DATA, SWAP_PENDING, SWAP_DONE} !== 35'd0)
      $display("FAIL reset_outputs got valid=%b data=%h pend=%b done=%b exp all 0",
               OVERLAY_VALID, OVERLAY_DATA, SWAP_PENDING, SWAP_DONE);
    else pass_cnt++;
    RST = 1'b0;
    @(posedge VIDCLK);
    #1;
  endtask

  task automatic test_flat();
    logic ov; logic [31:0] od; logic [32:0] e;
    WIDTH = 12'd8; HEIGHT = 12'd8; GRID_EN = 1'b0; TRACE_COLOR = 32'h00FF0000;
    for (int i = 0; i < 8; i++) write_sample(i, 3);
    pulse_swap();
    total_cnt++;
    if (SWAP_PENDING !== 1'b1) $display("FAIL flat_pending got %b exp 1", SWAP_PENDING);
    else pass_cnt++;
    do_sync(1'b0);
    total_cnt++;
    if (SWAP_DONE !== exp_done) $display("FAIL flat_done got %b exp %b", SWAP_DONE, exp_done);
    else pass_cnt++;
    @(posedge VIDCLK); #1;
    total_cnt++;
    if ({SWAP_DONE, SWAP_PENDING} !== 2'b00)
      $display("FAIL flat_done_clear got done=%b pend=%b exp 0 0", SWAP_DONE, SWAP_PENDING);
    else pass_cnt++;
    idle(4);
    for (int r = 0; r <= 8; r++) begin
      for (int x = 0; x < 8; x++) begin
        consume(ov, od);
        e = ref_pixel(x, r);
        total_cnt++;
        if ({ov, od} !== e) $display("FAIL flat_px(%0d,%0d) got %b/%h exp %b/%h", x, r, ov, od, e[32], e[31:0]);
        else pass_cnt++;
      end
      idle(4);
    end
  endtask

  task automatic test_segment();
    logic ov; logic [31:0] od; logic [32:0] e;
    TRACE_COLOR = 32'h00FF0000;
    write_sample(0, 0);
    for (int i = 1; i < 8; i++) write_sample(i, 7);
    do_sync(1'b1);
    total_cnt++;
    if (SWAP_DONE !== exp_done || exp_done !== 1'b1)
      $display("FAIL segment_same_cycle_swap got %b exp 1", SWAP_DONE);
    else pass_cnt++;
    idle(4);
    for (int r = 0; r < 8; r++) begin
      for (int x = 0; x < 8; x++) begin
        consume(ov, od);
        e = ref_pixel(x, r);
        total_cnt++;
        if ({ov, od} !== e) $display("FAIL segment_px(%0d,%0d) got %b/%h exp %b/%h", x, r, ov, od, e[32], e[31:0]);
        else pass_cnt++;
      end
      // Back-bank write mid-frame must not disturb the displayed trace.
      if (r == 3) write_sample(5, 2);
      idle(4);
    end
  endtask

  task automatic test_grid();
    logic ov; logic [31:0] od; logic [32:0] e;
    WIDTH = 12'd120; HEIGHT = 12'd120; GRID_EN = 1'b1; GRID_COLOR = 32'h0000FF00;
    for (int i = 0; i < 120; i++) write_sample(i, 200);
    do_sync(1'b1);
    idle(4);
    for (int r = 0; r < 120; r++) begin
      for (int x = 0; x < 120; x++) begin
        consume(ov, od);
        e = ref_pixel(x, r);
        total_cnt++;
        if ({ov, od} !== e) $display("FAIL grid_px(%0d,%0d) got %b/%h exp %b/%h", x, r, ov, od, e[32], e[31:0]);
        else pass_cnt++;
      end
      idle(4);
    end
  endtask

  task automatic test_back_to_back();
    logic ov; logic [31:0] od; logic [32:0] e;
    WIDTH = 12'd64; HEIGHT = 12'd6; GRID_EN = 1'b1;
    TRACE_COLOR = $urandom; GRID_COLOR = $urandom;
    for (int i = 0; i < 64; i++) write_sample(i, $urandom_range(0, 7));
    do_sync(1'b1);
    idle(4);
    for (int r = 0; r < 7; r++) begin
      for (int x = 0; x < 64; x++) begin
        consume(ov, od);
        e = ref_pixel(x, r);
        total_cnt++;
        if ({ov, od} !== e) $display("FAIL b2b_px(%0d,%0d) got %b/%h exp %b/%h", x, r, ov, od, e[32], e[31:0]);
        else pass_cnt++;
      end
      idle(4);
    end
  endtask

  task automatic test_random();
    logic ov; logic [31:0] od; logic [32:0] e;
    int w, h;
    for (int it = 0; it < 3; it++) begin
      w = $urandom_range(1, 40);
      h = $urandom_range(1, 30);
      WIDTH = 12'(w); HEIGHT = 12'(h);
      GRID_EN = 1'($urandom_range(0, 1));
      TRACE_COLOR = $urandom; GRID_COLOR = $urandom;
      for (int i = 0; i < w; i++) write_sample(i, $urandom_range(0, h + 3));
      pulse_swap();
      pulse_swap();
      do_sync(1'b0);
      total_cnt++;
      if (SWAP_DONE !== 1'b1 || exp_done !== 1'b1) $display("FAIL rand_double_swap_done got %b exp 1", SWAP_DONE);
      else pass_cnt++;
      idle(4);
      for (int x = 0; x < w / 2; x++) begin
        consume(ov, od);
        e = ref_pixel(x, 0);
        total_cnt++;
        if ({ov, od} !== e) $display("FAIL rand_partial_px(%0d,0) got %b/%h exp %b/%h", x, ov, od, e[32], e[31:0]);
        else pass_cnt++;
      end
      do_sync(1'b0);
      total_cnt++;
      if (SWAP_DONE !== 1'b0) $display("FAIL rand_midframe_sync_done got %b exp 0", SWAP_DONE);
      else pass_cnt++;
      idle(4);
      for (int r = 0; r <= h; r++) begin
        for (int x = 0; x < w; x++) begin
          consume(ov, od);
          e = ref_pixel(x, r);
          total_cnt++;
          if ({ov, od} !== e) $display("FAIL rand_px(%0d,%0d) got %b/%h exp %b/%h", x, r, ov, od, e[32], e[31:0]);
          else pass_cnt++;
        end
        idle(4);
      end
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 1024; a++) ref_mem[b][a] = 0;
    test_reset();
    test_flat();
    test_segment();
    test_grid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
